// File: rtl/mc_controller.sv
`timescale 1ns/1ps
// mc_controller
// Multi-cycle control FSM for the single-fetch datapath. It sequences one
// instruction at a time through FETCH/DECODE/EXEC/MEM/WB and drives every
// write enable and mux select. Datapath selects are decoded from the IR
// alone; write enables are gated by the current state. A retired-instruction
// counter and a sticky illegal-instruction flag are also kept here.
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  npc_sel,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_sel,
    output logic        alu_src,
    output logic [1:0]  ext_op,
    output logic [2:0]  alu_op,
    output logic        mem_we,
    output logic [2:0]  state,
    output logic [31:0] instr_count,
    output logic        illegal
);

    // State encoding (also exported on the debug port).
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    // Primary opcodes.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes.
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Next-PC selects.
    localparam logic [1:0] NPC_SEQ  = 2'b00;
    localparam logic [1:0] NPC_BEQ  = 2'b01;
    localparam logic [1:0] NPC_J    = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    // Register destination selects.
    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_RA   = 2'b10;

    // Write-data selects.
    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_MEM   = 2'b01;
    localparam logic [1:0] WD_PC4   = 2'b10;

    // Extender modes.
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_HIGH = 2'b10;

    // ALU operations.
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;

    logic [2:0] state_q;
    logic [2:0] state_d;

    logic [5:0] opcode;
    logic [5:0] funct;

    logic is_nop;
    logic is_rtype;
    logic is_addu;
    logic is_subu;
    logic is_jr;
    logic is_ori;
    logic is_lui;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_j;
    logic is_jal;
    logic is_illegal;
    logic ends_in_decode;
    logic is_alu_wb;

    // The branch condition is applied by the fetch unit, so it is not
    // needed here; it is only tied off to keep the port list uniform.
    logic unused_zero;
    assign unused_zero = zero;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    // All-zero word is the canonical nop; any other R-type with an unknown
    // function code falls through to illegal.
    assign is_nop     = (instr == 32'd0);
    assign is_rtype   = (opcode == OP_RTYPE) && !is_nop;
    assign is_addu    = is_rtype && (funct == FN_ADDU);
    assign is_subu    = is_rtype && (funct == FN_SUBU);
    assign is_jr      = is_rtype && (funct == FN_JR);
    assign is_ori     = (opcode == OP_ORI);
    assign is_lui     = (opcode == OP_LUI);
    assign is_lw      = (opcode == OP_LW);
    assign is_sw      = (opcode == OP_SW);
    assign is_beq     = (opcode == OP_BEQ);
    assign is_j       = (opcode == OP_J);
    assign is_jal     = (opcode == OP_JAL);
    assign is_illegal = !(is_nop | is_addu | is_subu | is_jr | is_ori | is_lui |
                          is_lw | is_sw | is_beq | is_j | is_jal);

    // Instructions that retire straight out of DECODE.
    assign ends_in_decode = is_j | is_jal | is_jr | is_nop | is_illegal;
    // ALU results written back in WB without a memory access.
    assign is_alu_wb      = is_addu | is_subu | is_ori | is_lui;

    assign state = state_q;

    // State register; reset returns the sequencer to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection from the current state and the decoded IR.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = ends_in_decode ? S_FETCH : S_EXEC;
            end
            S_EXEC: begin
                if (is_lw | is_sw) begin
                    state_d = S_MEM;
                end else if (is_alu_wb) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                state_d = is_lw ? S_WB : S_FETCH;
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State-gated write enables; npc_sel stays sequential unless the PC moves.
    always_comb begin
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        npc_sel = NPC_SEQ;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    ir_we = 1'b1;
                end
                S_DECODE: begin
                    if (is_j) begin
                        pc_we   = 1'b1;
                        npc_sel = NPC_J;
                    end else if (is_jal) begin
                        reg_we  = 1'b1;
                        pc_we   = 1'b1;
                        npc_sel = NPC_J;
                    end else if (is_jr) begin
                        pc_we   = 1'b1;
                        npc_sel = NPC_JR;
                    end else if (is_nop | is_illegal) begin
                        pc_we   = 1'b1;
                    end
                end
                S_EXEC: begin
                    if (is_beq) begin
                        pc_we   = 1'b1;
                        npc_sel = NPC_BEQ;
                    end
                end
                S_MEM: begin
                    if (is_sw) begin
                        mem_we = 1'b1;
                        pc_we  = 1'b1;
                    end
                end
                S_WB: begin
                    reg_we = 1'b1;
                    pc_we  = 1'b1;
                end
                default: begin
                    ir_we = 1'b0;
                end
            endcase
        end
    end

    // Datapath selects decoded from the IR alone, independent of state.
    always_comb begin
        reg_dst = DST_RT;
        wd_sel  = WD_ALU;
        alu_src = 1'b0;
        ext_op  = EXT_ZERO;
        alu_op  = ALU_ADD;
        if (is_addu) begin
            reg_dst = DST_RD;
            alu_op  = ALU_ADD;
        end else if (is_subu) begin
            reg_dst = DST_RD;
            alu_op  = ALU_SUB;
        end else if (is_ori) begin
            alu_src = 1'b1;
            ext_op  = EXT_ZERO;
            alu_op  = ALU_OR;
        end else if (is_lui) begin
            alu_src = 1'b1;
            ext_op  = EXT_HIGH;
            alu_op  = ALU_OR;
        end else if (is_lw) begin
            wd_sel  = WD_MEM;
            alu_src = 1'b1;
            ext_op  = EXT_SIGN;
            alu_op  = ALU_ADD;
        end else if (is_sw) begin
            alu_src = 1'b1;
            ext_op  = EXT_SIGN;
            alu_op  = ALU_ADD;
        end else if (is_beq) begin
            alu_src = 1'b0;
            alu_op  = ALU_SUB;
        end else if (is_jal) begin
            reg_dst = DST_RA;
            wd_sel  = WD_PC4;
        end
    end

    // Retired-instruction counter: one count per PC update, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count <= 32'd0;
        end else if (pc_we) begin
            instr_count <= instr_count + 32'd1;
        end
    end

    // Sticky flag raised when an undefined encoding retires.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal <= 1'b0;
        end else if (pc_we && is_illegal) begin
            illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
`timescale 1ns/1ps
// Self-checking bench for mc_controller: an instruction-level model predicts
// every output on every cycle, plus literal expectations at key points.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        zero = 1'b0;
    logic        ir_we, pc_we, reg_we, mem_we, alu_src, illegal;
    logic [1:0]  npc_sel, reg_dst, wd_sel, ext_op;
    logic [2:0]  alu_op, state;
    logic [31:0] instr_count;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .zero        (zero),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .npc_sel     (npc_sel),
        .reg_we      (reg_we),
        .reg_dst     (reg_dst),
        .wd_sel      (wd_sel),
        .alu_src     (alu_src),
        .ext_op      (ext_op),
        .alu_op      (alu_op),
        .mem_we      (mem_we),
        .state       (state),
        .instr_count (instr_count),
        .illegal     (illegal)
    );

    int checks = 0;
    int errors = 0;

    localparam int K_NOP  = 0;
    localparam int K_ILL  = 1;
    localparam int K_ADDU = 2;
    localparam int K_SUBU = 3;
    localparam int K_JR   = 4;
    localparam int K_ORI  = 5;
    localparam int K_LUI  = 6;
    localparam int K_LW   = 7;
    localparam int K_SW   = 8;
    localparam int K_BEQ  = 9;
    localparam int K_J    = 10;
    localparam int K_JAL  = 11;

    // Model state: instruction in flight, cycle index within it, counters.
    int          m_kind = K_NOP;
    int          m_k = 0;
    logic        m_rst = 1'b1;
    logic [31:0] m_count = 32'd0;
    logic        m_ill = 1'b0;
    logic        m_active = 1'b0;

    function automatic int kind_of(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        if (w == 32'd0) return K_NOP;
        case (op)
            6'h00: begin
                case (fn)
                    6'h21:   return K_ADDU;
                    6'h23:   return K_SUBU;
                    6'h08:   return K_JR;
                    default: return K_ILL;
                endcase
            end
            6'h0d:   return K_ORI;
            6'h0f:   return K_LUI;
            6'h23:   return K_LW;
            6'h2b:   return K_SW;
            6'h04:   return K_BEQ;
            6'h02:   return K_J;
            6'h03:   return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    // Cycles from FETCH to the retiring cycle, inclusive.
    function automatic int len_of(input int kd);
        case (kd)
            K_BEQ:                    return 3;
            K_ADDU, K_SUBU, K_ORI,
            K_LUI, K_SW:              return 4;
            K_LW:                     return 5;
            default:                  return 2;
        endcase
    endfunction

    // Cycle k of an instruction: FETCH, DECODE, EXEC, then MEM for memory
    // ops, and WB for anything reaching a fifth step or a non-memory fourth.
    function automatic int state_at(input int kd, input int k);
        case (k)
            0:       return 0;
            1:       return 1;
            2:       return 2;
            3:       return (kd == K_LW || kd == K_SW) ? 3 : 4;
            default: return 4;
        endcase
    endfunction

    function automatic int writes_reg(input int kd);
        return (kd == K_ADDU || kd == K_SUBU || kd == K_ORI || kd == K_LUI ||
                kd == K_LW || kd == K_JAL) ? 1 : 0;
    endfunction

    function automatic int npc_of(input int kd);
        case (kd)
            K_J, K_JAL: return 2;
            K_JR:       return 3;
            K_BEQ:      return 1;
            default:    return 0;
        endcase
    endfunction

    function automatic int dst_of(input int kd);
        case (kd)
            K_ADDU, K_SUBU: return 1;
            K_JAL:          return 2;
            default:        return 0;
        endcase
    endfunction

    function automatic int wd_of(input int kd);
        case (kd)
            K_LW:    return 1;
            K_JAL:   return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int src_of(input int kd);
        return (kd == K_ORI || kd == K_LUI || kd == K_LW || kd == K_SW) ? 1 : 0;
    endfunction

    function automatic int ext_of(input int kd);
        case (kd)
            K_LUI:      return 2;
            K_LW, K_SW: return 1;
            default:    return 0;
        endcase
    endfunction

    function automatic int aluop_of(input int kd);
        case (kd)
            K_SUBU, K_BEQ: return 1;
            K_ORI, K_LUI:  return 2;
            default:       return 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h instr=%h t=%0t", name, act, exp, instr, $time);
        end
    endtask

    int   c_kd;
    logic c_fin;

    // Every cycle, compare all DUT outputs against the model.
    always @(negedge clk) begin
        if (m_active) begin
            c_kd  = kind_of(instr);
            c_fin = !m_rst && (m_k == len_of(m_kind) - 1);
            chk("state",       32'(state),       32'(state_at(m_kind, m_k)));
            chk("ir_we",       32'(ir_we),       32'(!m_rst && m_k == 0));
            chk("pc_we",       32'(pc_we),       32'(c_fin));
            chk("reg_we",      32'(reg_we),      32'(c_fin && writes_reg(m_kind) == 1));
            chk("mem_we",      32'(mem_we),      32'(c_fin && m_kind == K_SW));
            chk("npc_sel",     32'(npc_sel),     c_fin ? 32'(npc_of(m_kind)) : 32'd0);
            chk("reg_dst",     32'(reg_dst),     32'(dst_of(c_kd)));
            chk("wd_sel",      32'(wd_sel),      32'(wd_of(c_kd)));
            chk("alu_src",     32'(alu_src),     32'(src_of(c_kd)));
            chk("ext_op",      32'(ext_op),      32'(ext_of(c_kd)));
            chk("alu_op",      32'(alu_op),      32'(aluop_of(c_kd)));
            chk("instr_count", instr_count,      m_count);
            chk("illegal",     32'(illegal),     32'(m_ill));
        end
    end

    // Present one instruction from its FETCH cycle until it retires.
    task automatic exec(input logic [31:0] w);
        int n;
        instr  = w;
        m_kind = kind_of(w);
        m_k    = 0;
        n      = len_of(m_kind);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i == n - 1) begin
                m_count = m_count + 32'd1;
                if (m_kind == K_ILL) m_ill = 1'b1;
                m_k = 0;
            end else begin
                m_k = m_k + 1;
            end
        end
    endtask

    // Start an instruction but stop after a given number of cycles.
    task automatic exec_partial(input logic [31:0] w, input int ncyc);
        instr  = w;
        m_kind = kind_of(w);
        m_k    = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            m_k = m_k + 1;
        end
    endtask

    task automatic do_reset(input int ncyc);
        reset = 1'b1;
        m_rst = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            m_k     = 0;
            m_count = 32'd0;
            m_ill   = 1'b0;
        end
        reset = 1'b0;
        m_rst = 1'b0;
    endtask

    initial begin
        // Power-up reset: two edges with reset held high.
        @(posedge clk);
        #1;
        m_active = 1'b1;
        @(posedge clk);
        #1;
        chk("lit_reset_state", 32'(state), 32'd0);
        chk("lit_reset_count", instr_count, 32'd0);
        chk("lit_reset_ill",   32'(illegal), 32'd0);
        chk("lit_reset_ir_we", 32'(ir_we), 32'd0);
        reset = 1'b0;
        m_rst = 1'b0;
        #1;
        chk("lit_first_ir_we", 32'(ir_we), 32'd1);

        // ALU-class and short instructions.
        exec(32'h000A0821);                       // addu
        chk("lit_count_addu", instr_count, 32'd1);
        exec(32'h00221823);                       // subu
        exec(32'h3C011234);                       // lui
        exec(32'h08000010);                       // j
        exec(32'h00000000);                       // nop
        chk("lit_count_5", instr_count, 32'd5);

        // Memory pair after a fresh reset.
        do_reset(2);
        exec(32'h8C220004);                       // lw
        exec(32'hAC220008);                       // sw
        chk("lit_count_lwsw", instr_count, 32'd2);

        // beq takes the same path whatever zero says.
        instr = 32'h10220003;
        #1;
        chk("lit_beq_alu_op",  32'(alu_op),  32'd1);
        chk("lit_beq_alu_src", 32'(alu_src), 32'd0);
        zero = 1'b1;
        exec(32'h10220003);
        zero = 1'b0;
        exec(32'h10220003);
        chk("lit_count_beq", instr_count, 32'd4);

        // jal / jr.
        instr = 32'h0C000C00;
        #1;
        chk("lit_jal_reg_dst", 32'(reg_dst), 32'd2);
        chk("lit_jal_wd_sel",  32'(wd_sel),  32'd2);
        exec(32'h0C000C00);
        exec(32'h03E00008);
        chk("lit_count_jr", instr_count, 32'd6);

        // Illegal encodings and the sticky flag.
        exec(32'hFC000000);
        chk("lit_ill_set", 32'(illegal), 32'd1);
        exec(32'h34220005);                       // ori
        chk("lit_ill_held", 32'(illegal), 32'd1);
        exec(32'h00000022);                       // unsupported R-type funct
        chk("lit_count_ill", instr_count, 32'd9);
        do_reset(1);
        chk("lit_ill_clear",   32'(illegal), 32'd0);
        chk("lit_count_clear", instr_count, 32'd0);

        // Reset during EXEC of lw abandons it.
        exec(32'h000A0821);
        exec_partial(32'h8C220004, 2);
        chk("lit_abort_exec", 32'(state), 32'd2);
        do_reset(2);
        chk("lit_abort_state", 32'(state), 32'd0);
        chk("lit_abort_count", instr_count, 32'd0);
        exec(32'h000A0821);
        chk("lit_after_abort", instr_count, 32'd1);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
